nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit add/subtract unit that drives the team's 4-bit KSA_Adder
//  (a, b, cin -> s, cout) one nibble per clock, least-significant nibble first.
//  The nibble carry is registered between cycles.
//  Sits between the ALU operand/opcode stage (valid/ready producer) and the
//  result/flag writeback stage (valid/ready consumer).
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of 4 and >= 8
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      unit can accept an operation
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_op      in   1      0 = A+B, 1 = A-B
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts the result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry out of MSB (sub: 1 = no borrow)
//  out_ovf    out  1      two's-complement signed overflow
//  out_zero   out  1      out_sum == 0
// BEHAVIOUR
//  Reset (rst_n low, asynchronous):
//   - state = IDLE; nibble index, carry, operand and sum registers cleared.
//   - out_valid/out_sum/out_cout/out_ovf/out_zero = 0.
//   - in_ready = 1 (in_ready is asserted only in IDLE).
//   - Reset mid-operation aborts it; no partial result is ever presented.
//  FSM IDLE -> RUN -> DONE -> IDLE; N = WIDTH/4.
//   IDLE: on in_valid & in_ready:
//    - latch A.
//    - latch B_eff = in_op ? ~in_b : in_b.
//    - carry = in_op.
//    - idx = 0.
//    - go to RUN.
//   RUN: adder fed A[idx*4+:4], B_eff[idx*4+:4], carry.
//    - Each edge: s -> sum[idx*4+:4], cout -> carry, idx += 1.
//    - On the edge that processes idx == N-1 -> DONE.
//   DONE: out_valid = 1; out_* stable.
//    - On out_ready -> IDLE; out_valid drops.
//    - No accept in that same cycle; in_ready is 0 in RUN and DONE.
//  Latency: out_valid high N cycles after the accepting edge.
//   - Throughput: at most one operation per N+2 cycles.
//  Flags, computed when entering DONE:
//   - cout = final carry.
//   - ovf = (A[MSB] == B_eff[MSB]) & (sum[MSB] != A[MSB]).
//   - zero = ~|sum.
//  in_a/in_b/in_op are sampled only on the accepting edge; later changes are ignored.
//  in_valid while busy: not accepted and not dropped; the producer must hold it.
//  out_ready while not in DONE has no effect.
//  idx width = $clog2(N); wraps only via reset to 0 on accept.
// STRUCTURE
//  Shared package alu_pkg:
//   - NIBBLE_W = 4.
//   - state encoding {IDLE, RUN, DONE}.
//   - op encoding OP_ADD = 1'b0, OP_SUB = 1'b1.
//  Single sub-module: one KSA_Adder instance; everything else is local FSM/datapath.
// TESTING (WIDTH=16)
//  1. add 0x1234 + 0x0FCD, out_ready = 1
//     -> out_valid 4 cycles after accept; sum 0x2201, cout 0, ovf 0, zero 0.
//  2. add 0xFFFF + 0x0001 -> sum 0x0000, cout 1, ovf 0, zero 1.
//  3. add 0x7FFF + 0x0001 -> sum 0x8000, cout 0, ovf 1.
//     sub 0x8000 - 0x0001 -> sum 0x7FFF, cout 1, ovf 1.
//  4. sub 0x0005 - 0x0007 -> sum 0xFFFE, cout 0 (borrow), ovf 0, zero 0.
//  5. out_ready held low 10 cycles while a second op has in_valid high:
//     -> out_* stable, in_ready 0, second op not taken;
//     -> after out_ready, the second op is accepted no earlier than 1 cycle later.
//  6. rst_n pulsed low after 2 RUN cycles:
//     -> all outputs 0 immediately, in_ready 1 after release;
//     -> next op 0x00FF + 0x0001 yields 0x0100.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: nibble width, serial-adder FSM states and opcode encoding.
package alu_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_serial_adder_ksa.sv
// KSA_Adder: 4-bit Kogge-Stone adder with carry in/out, used one nibble per cycle.
module KSA_Adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [3:0] g0, p0, g1, p1, g2, p2;
   logic [4:0] c;

   always_comb begin
      g0 = a & b;
      p0 = a ^ b;
      g1 = g0;
      p1 = p0;
      for (int i = 1; i < 4; i++) begin
         g1[i] = g0[i] | (p0[i] & g0[i-1]);
         p1[i] = p0[i] & p0[i-1];
      end
      g2 = g1;
      p2 = p1;
      for (int i = 2; i < 4; i++) begin
         g2[i] = g1[i] | (p1[i] & g1[i-2]);
         p2[i] = p1[i] & p1[i-2];
      end
      // Group terms span bits [i:0]; fold in cin to get the carry into bit i+1.
      c[0] = cin;
      for (int i = 0; i < 4; i++)
         c[i+1] = g2[i] | (p2[i] & cin);
      s    = p0 ^ c[3:0];
      cout = c[4];
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract: one KSA_Adder nibble per clock, LSB nibble first,
// with valid/ready handshakes on both sides.
module nibble_serial_adder
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int N     = WIDTH / NIBBLE_W;
   localparam int IDX_W = $clog2(N);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

   logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
   logic                nib_c;
   logic                last;

   assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
   assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
   assign last  = (idx_q == IDX_W'(N-1));

   KSA_Adder u_ksa (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .s    (nib_s),
      .cout (nib_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (last)     state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      if (state_q == IDLE && in_valid) begin
         // Subtract as A + ~B + 1: the +1 rides in on the initial carry.
         a_d     = in_a;
         b_d     = (in_op == OP_SUB) ? ~in_b : in_b;
         carry_d = in_op;
         idx_d   = '0;
      end else if (state_q == RUN) begin
         sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_s;
         carry_d = nib_c;
         idx_d   = last ? idx_q : idx_q + 1'b1;
         if (last) begin
            cout_d = nib_c;
            ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (nib_s[NIBBLE_W-1] != a_q[WIDTH-1]);
            zero_d = ~|sum_d;
         end
      end
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      out_sum   = out_valid ? sum_q : '0;
      out_cout  = out_valid & cout_q;
      out_ovf   = out_valid & ovf_q;
      out_zero  = out_valid & zero_q;
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed checks of nibble_serial_adder against an arithmetic model.
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;
   localparam int N     = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready, in_op;
   logic [WIDTH-1:0] in_a, in_b;
   logic             out_valid, out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout, out_ovf, out_zero;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Plain two's-complement arithmetic on a WIDTH+1 bit result.
   task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic op,
                        output logic [WIDTH-1:0] s, output logic c, output logic v, output logic z);
      logic [WIDTH:0] full;
      if (op) full = {1'b0, a} + {1'b0, ~b} + 1;
      else    full = {1'b0, a} + {1'b0, b};
      s = full[WIDTH-1:0];
      c = full[WIDTH];
      if (op) v = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      else    v = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      z = (s == '0);
   endtask

   task automatic check_result(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic op);
      logic [WIDTH-1:0] s;
      logic c, v, z;
      model(a, b, op, s, c, v, z);
      chk({tag, "_sum"},  out_sum,  s);
      chk({tag, "_cout"}, out_cout, c);
      chk({tag, "_ovf"},  out_ovf,  v);
      chk({tag, "_zero"}, out_zero, z);
   endtask

   task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic op, input int hold);
      int cyc;
      logic [WIDTH-1:0] s;
      logic c, v, z;
      model(a, b, op, s, c, v, z);
      @(negedge clk);
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_op = 1'($urandom);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, cyc, N);
      check_result(tag, a, b, op);
      repeat (hold) begin
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, out_valid, 1'b1);
         chk({tag, "_hold_sum"},   out_sum,   s);
         chk({tag, "_hold_rdy"},   in_ready,  1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, out_valid, 1'b0);
      chk({tag, "_idle_rdy"},   in_ready,  1'b1);
   endtask

   initial begin
      logic [WIDTH-1:0] s2;
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_sum",   out_sum,   '0);
      chk("rst_flags", {out_cout, out_ovf, out_zero}, 3'b000);
      chk("rst_ready", in_ready,  1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_op("add1",   16'h1234, 16'h0FCD, 1'b0, 0);
      chk("add1_ref", 32'(16'h1234 + 16'h0FCD), 32'h2201);
      do_op("addwrap", 16'hFFFF, 16'h0001, 1'b0, 0);
      do_op("addovf",  16'h7FFF, 16'h0001, 1'b0, 1);
      do_op("subovf",  16'h8000, 16'h0001, 1'b1, 0);
      do_op("subbrw",  16'h0005, 16'h0007, 1'b1, 2);
      do_op("subzero", 16'hA5A5, 16'hA5A5, 1'b1, 0);

      // Backpressure with a second operation waiting at the input.
      @(negedge clk);
      in_a = 16'h4000; in_b = 16'h4000; in_op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_a = 16'h0100; in_b = 16'h0023; in_op = 1'b1;
      repeat (N) @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1'b1);
      check_result("bp_first", 16'h4000, 16'h4000, 1'b0);
      repeat (10) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", out_valid, 1'b1);
         chk("bp_hold_sum",   out_sum,   16'h8000);
         chk("bp_hold_ovf",   out_ovf,   1'b1);
         chk("bp_hold_rdy",   in_ready,  1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_drop",      out_valid, 1'b0);
      chk("bp_not_taken", in_ready,  1'b1);
      @(posedge clk); #1;
      chk("bp_taken", in_ready, 1'b0);
      in_valid = 1'b0;
      repeat (N) @(posedge clk);
      #1;
      chk("bp2_valid", out_valid, 1'b1);
      check_result("bp_second", 16'h0100, 16'h0023, 1'b1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset in the middle of an operation.
      @(negedge clk);
      in_a = 16'hFFFF; in_b = 16'hFFFF; in_op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_sum",   out_sum,   '0);
      chk("mid_rst_flags", {out_cout, out_ovf, out_zero}, 3'b000);
      chk("mid_rst_ready", in_ready,  1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", in_ready, 1'b1);
      do_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 0);
      model(16'h00FF, 16'h0001, 1'b0, s2, in_op, in_op, in_op);

      for (int i = 0; i < 40; i++)
         do_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
